// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared widths, assembly state encoding and stream type codes
//               for the AES output block collector.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int WORD_W        = 16;
    localparam int BLK_W         = 128;
    localparam int WORDS_PER_BLK = 8;
    localparam int CNT_W         = 3;

    // Assembly state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    // Type codes carried on the core's output stream
    localparam logic TYPE_ENC = 1'b0;
    localparam logic TYPE_DEC = 1'b1;

endpackage : aes_pkg
`default_nettype wire

// File: rtl/blk_fifo.sv
`default_nettype none
// ============================================================================
// Module      : blk_fifo
// Description : First-word-fall-through FIFO. A push while full is ignored
//               unless a pop happens in the same cycle; a pop while empty is
//               ignored. Head data reads as zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module blk_fifo #(
    parameter int WIDTH  = 129,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  head_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (ADDR_W+1)'(DEPTH));
    assign count     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state: qualify push/pop, advance wrapping pointers and occupancy
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (ADDR_W+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (ADDR_W+1)'(1);
        end
    end

    // Storage and pointer registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : blk_fifo
`default_nettype wire

// File: rtl/block_collector.sv
`default_nettype none
// ============================================================================
// Module      : block_collector
// Description : Packs eight 16-bit AES output words (first word = MSB) into a
//               128-bit block, buffers blocks in a FWFT FIFO and reports
//               overflow / type inconsistency as sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module block_collector
    import aes_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vin,
    input  logic                tin,
    input  logic [WORD_W-1:0]   din,
    input  logic                flush,
    output logic                blk_valid,
    output logic                blk_type,
    output logic [BLK_W-1:0]    blk_data,
    input  logic                blk_ready,
    output logic [ADDR_W:0]     fifo_count,
    output logic                partial,
    output logic                overflow,
    output logic                type_err,
    input  logic                clr_err
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BLK_W-1:0] asm_q, asm_d;
    logic             type_q, type_d;
    logic             overflow_q, overflow_d;
    logic             type_err_q, type_err_d;
    logic             blk_done;
    logic             type_mis;
    logic [BLK_W:0]   push_data;
    logic [BLK_W:0]   head_data;
    logic             fifo_full;
    logic             fifo_empty;

    // The completing word goes straight into the pushed block, bypassing asm_q
    assign push_data = {type_q, asm_q[BLK_W-1:WORD_W], din};

    blk_fifo #(
        .WIDTH  (BLK_W + 1),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_blk_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (blk_done),
        .push_data (push_data),
        .pop       (blk_ready),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign blk_valid = !fifo_empty;
    assign blk_type  = head_data[BLK_W];
    assign blk_data  = head_data[BLK_W-1:0];
    assign partial   = (state_q == ST_FILL);
    assign overflow  = overflow_q;
    assign type_err  = type_err_q;

    // Assembly FSM: place words MSB-first, detect block completion and type changes
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        type_d   = type_q;
        blk_done = 1'b0;
        type_mis = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (vin) begin
            asm_d[BLK_W-1-WORD_W*int'(cnt_q) -: WORD_W] = din;
            if (state_q == ST_IDLE) begin
                type_d  = tin;
                state_d = ST_FILL;
                cnt_d   = CNT_W'(1);
            end else begin
                type_mis = (tin != type_q);
                if (cnt_q == CNT_W'(WORDS_PER_BLK - 1)) begin
                    blk_done = 1'b1;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Sticky flags: a set event outranks a simultaneous clear
    always_comb begin
        overflow_d = (overflow_q & ~clr_err) | (blk_done & fifo_full & ~blk_ready);
        type_err_d = (type_err_q & ~clr_err) | type_mis;
    end

    // Assembly and flag registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            asm_q      <= '0;
            type_q     <= 1'b0;
            overflow_q <= 1'b0;
            type_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            asm_q      <= asm_d;
            type_q     <= type_d;
            overflow_q <= overflow_d;
            type_err_q <= type_err_d;
        end
    end

endmodule : block_collector
`default_nettype wire

// File: tb/tb_block_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_collector
// Description : Self-checking bench for block_collector: queue-based block
//               model compared every cycle plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_collector;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         vin = 1'b0;
    logic         tin = 1'b0;
    logic [15:0]  din = '0;
    logic         flush = 1'b0;
    logic         blk_ready = 1'b0;
    logic         clr_err = 1'b0;
    logic         blk_valid;
    logic         blk_type;
    logic [127:0] blk_data;
    logic [2:0]   fifo_count;
    logic         partial;
    logic         overflow;
    logic         type_err;

    int checks = 0;
    int errors = 0;

    block_collector #(.FIFO_DEPTH(4), .ADDR_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .vin        (vin),
        .tin        (tin),
        .din        (din),
        .flush      (flush),
        .blk_valid  (blk_valid),
        .blk_type   (blk_type),
        .blk_data   (blk_data),
        .blk_ready  (blk_ready),
        .fifo_count (fifo_count),
        .partial    (partial),
        .overflow   (overflow),
        .type_err   (type_err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0]  wbuf [$];
    logic [128:0] mq [$];
    logic         m_type = 1'b0;
    logic         m_ovf  = 1'b0;
    logic         m_terr = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbuf.delete();
            mq.delete();
            m_type = 1'b0;
            m_ovf  = 1'b0;
            m_terr = 1'b0;
        end else begin
            automatic bit popping  = (mq.size() != 0) && blk_ready;
            automatic bit full_pre = (mq.size() == 4);
            automatic bit set_o    = 1'b0;
            automatic bit set_t    = 1'b0;
            automatic logic [127:0] blk = '0;
            if (popping) void'(mq.pop_front());
            if (flush) begin
                wbuf.delete();
            end else if (vin) begin
                if (wbuf.size() == 0) m_type = tin;
                else if (tin != m_type) set_t = 1'b1;
                wbuf.push_back(din);
                if (wbuf.size() == 8) begin
                    foreach (wbuf[i]) blk = {blk[111:0], wbuf[i]};
                    if (!full_pre || popping) mq.push_back({m_type, blk});
                    else set_o = 1'b1;
                    wbuf.delete();
                end
            end
            m_ovf  = set_o | (m_ovf & ~clr_err);
            m_terr = set_t | (m_terr & ~clr_err);
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        automatic logic [128:0] head = (mq.size() != 0) ? mq[0] : '0;
        chk("cyc_valid",    {128'b0, blk_valid}, {128'b0, mq.size() != 0});
        chk("cyc_head",     {blk_type, blk_data}, head);
        chk("cyc_count",    {126'b0, fifo_count}, 129'(mq.size()));
        chk("cyc_partial",  {128'b0, partial}, {128'b0, wbuf.size() != 0});
        chk("cyc_overflow", {128'b0, overflow}, {128'b0, m_ovf});
        chk("cyc_type_err", {128'b0, type_err}, {128'b0, m_terr});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w, input logic t);
        vin = 1'b1; din = w; tin = t;
        tick();
        vin = 1'b0;
    endtask

    function automatic logic [15:0] ref_word(input int i);
        logic [3:0] n;
        logic [3:0] m;
        n = 4'(2 * i);
        m = 4'(2 * i + 1);
        return {n, n, m, m};
    endfunction

    task automatic send_ref_block;
        for (int i = 0; i < 8; i++) send_word(ref_word(i), 1'b0);
    endtask

    task automatic send_tag_block(input logic [7:0] tag);
        for (int i = 0; i < 8; i++) send_word({tag, 8'(i)}, 1'b0);
    endtask

    task automatic drain;
        blk_ready = 1'b1;
        repeat (5) tick();
        blk_ready = 1'b0;
    endtask

    localparam logic [127:0] REF_BLK = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] TAG1_BLK = 128'h1100_1101_1102_1103_1104_1105_1106_1107;
    localparam logic [127:0] TAG2_BLK = 128'h2200_2201_2202_2203_2204_2205_2206_2207;

    initial begin
        #1 rst = 1'b0;
        #1;
        chk("rst_valid",    {128'b0, blk_valid}, 129'd0);
        chk("rst_count",    {126'b0, fifo_count}, 129'd0);
        chk("rst_partial",  {128'b0, partial}, 129'd0);
        chk("rst_flags",    {127'b0, overflow, type_err}, 129'd0);
        chk("rst_head",     {blk_type, blk_data}, 129'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Single block
        send_ref_block();
        chk("single_valid", {128'b0, blk_valid}, 129'd1);
        chk("single_data",  {1'b0, blk_data}, {1'b0, REF_BLK});
        chk("single_type",  {128'b0, blk_type}, 129'd0);
        chk("single_count", {126'b0, fifo_count}, 129'd1);
        drain();

        // Gapped input
        for (int i = 0; i < 8; i++) begin
            send_word(ref_word(i), 1'b0);
            tick();
            if (i == 3) chk("gap_partial", {128'b0, partial}, 129'd1);
        end
        chk("gap_data", {1'b0, blk_data}, {1'b0, REF_BLK});
        drain();

        // Overflow: five blocks, no readiness
        for (int b = 1; b <= 5; b++) send_tag_block(8'(b * 17));
        chk("ovf_count", {126'b0, fifo_count}, 129'd4);
        chk("ovf_flag",  {128'b0, overflow}, 129'd1);
        chk("ovf_head",  {1'b0, blk_data}, {1'b0, TAG1_BLK});
        drain();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("ovf_cleared", {128'b0, overflow}, 129'd0);

        // Full with simultaneous pop on the completing word
        for (int b = 1; b <= 4; b++) send_tag_block(8'(b * 17));
        for (int i = 0; i < 7; i++) send_word({8'h55, 8'(i)}, 1'b0);
        blk_ready = 1'b1;
        send_word(16'h5507, 1'b0);
        blk_ready = 1'b0;
        chk("fullpop_count", {126'b0, fifo_count}, 129'd4);
        chk("fullpop_ovf",   {128'b0, overflow}, 129'd0);
        chk("fullpop_head",  {1'b0, blk_data}, {1'b0, TAG2_BLK});
        drain();

        // Type error
        for (int i = 0; i < 8; i++) send_word(ref_word(i), (i < 4) ? 1'b1 : 1'b0);
        chk("terr_flag", {128'b0, type_err}, 129'd1);
        chk("terr_type", {128'b0, blk_type}, 129'd1);
        chk("terr_data", {1'b0, blk_data}, {1'b0, REF_BLK});
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        send_word(16'hA000, 1'b0);
        clr_err = 1'b1;
        send_word(16'hA001, 1'b1);
        clr_err = 1'b0;
        chk("terr_set_wins", {128'b0, type_err}, 129'd1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("terr_cleared", {128'b0, type_err}, 129'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        drain();

        // Flush discards partial words, including a same-cycle vin
        for (int i = 0; i < 3; i++) send_word(16'hDEAD, 1'b0);
        flush = 1'b1;
        send_word(16'hBEEF, 1'b0);
        flush = 1'b0;
        chk("flush_partial", {128'b0, partial}, 129'd0);
        send_ref_block();
        chk("flush_data",  {1'b0, blk_data}, {1'b0, REF_BLK});
        chk("flush_count", {126'b0, fifo_count}, 129'd1);

        // Asynchronous reset mid-block with two blocks queued
        send_tag_block(8'h11);
        for (int i = 0; i < 3; i++) send_word(16'h7777, 1'b0);
        chk("prerst_count", {126'b0, fifo_count}, 129'd2);
        rst = 1'b0;
        #1;
        chk("arst_valid",   {128'b0, blk_valid}, 129'd0);
        chk("arst_count",   {126'b0, fifo_count}, 129'd0);
        chk("arst_partial", {128'b0, partial}, 129'd0);
        chk("arst_head",    {blk_type, blk_data}, 129'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_block_collector
`default_nettype wire
